// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, registers the ROM word for decode, and applies
// redirect / illegal-op / interrupt / out-of-range vectoring.
module instr_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'd0,
  parameter logic [31:0] ILLOP_ADDR = 32'd4,
  parameter logic [31:0] XADR_ADDR  = 32'd8,
  parameter int          IMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] id_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus4_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        illop_i,
  input  logic        irq_i,
  output logic [31:0] xp_o,
  output logic        xp_valid_o
);

  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic [31:0] xp_q, xp_d;
  logic        xp_valid_q, xp_valid_d;
  logic        irq_pend_q, irq_pend_d;

  logic [31:0] target;
  logic        irq_take;
  logic        out_of_range;

  assign target       = redirect_addr_i & ~32'd3;
  assign irq_take     = irq_pend_q | irq_i;
  assign out_of_range = (pc_q >> 2) >= 32'(IMEM_WORDS);

  always_comb begin
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    xp_d          = xp_q;
    xp_valid_d    = 1'b0;
    irq_pend_d    = irq_pend_q | irq_i;

    if (illop_i && if_valid_q) begin
      // Illegal op wins; any pending interrupt waits for the following cycle.
      pc_d       = ILLOP_ADDR;
      if_valid_d = 1'b0;
      xp_d       = if_pc_q + 32'd4;
      xp_valid_d = 1'b1;
    end else if (irq_take) begin
      pc_d       = XADR_ADDR;
      if_valid_d = 1'b0;
      xp_valid_d = 1'b1;
      irq_pend_d = 1'b0;
      if (redirect_i)      xp_d = target + 32'd4;
      else if (if_valid_q) xp_d = if_pc_q + 32'd4;
      else                 xp_d = pc_q + 32'd4;
    end else if (redirect_i) begin
      pc_d       = target;
      if_valid_d = 1'b0;
    end else if (out_of_range) begin
      pc_d       = ILLOP_ADDR;
      if_valid_d = 1'b0;
      xp_d       = pc_q + 32'd4;
      xp_valid_d = 1'b1;
    end else if (!if_valid_q || if_ready_i) begin
      if_instr_d    = id_i;
      if_pc_d       = pc_q;
      if_pc_plus4_d = pc_q + 32'd4;
      if_valid_d    = 1'b1;
      pc_d          = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_ADDR;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
      xp_q          <= '0;
      xp_valid_q    <= 1'b0;
      irq_pend_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      xp_q          <= xp_d;
      xp_valid_q    <= xp_valid_d;
      irq_pend_q    <= irq_pend_d;
    end
  end

  assign pc_o          = pc_q;
  assign if_valid_o    = if_valid_q;
  assign if_instr_o    = if_instr_q;
  assign if_pc_o       = if_pc_q;
  assign if_pc_plus4_o = if_pc_plus4_q;
  assign xp_o          = xp_q;
  assign xp_valid_o    = xp_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized traffic
// compared against a behavioural fetch-stage model.
module tb_instr_fetch;

  localparam int WORDS = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_o;
  logic [31:0] id_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus4_o;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        illop_i;
  logic        irq_i;
  logic [31:0] xp_o;
  logic        xp_valid_o;

  logic [31:0] rom [WORDS];
  int n_chk = 0;
  int n_fail = 0;

  // behavioural model state
  logic [31:0] m_pc, m_instr, m_ipc, m_ip4, m_xp;
  logic        m_v, m_xpv, m_pend;

  instr_fetch #(
    .RESET_ADDR(32'd0), .ILLOP_ADDR(32'd4), .XADR_ADDR(32'd8), .IMEM_WORDS(WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_o(pc_o), .id_i(id_i),
    .if_valid_o(if_valid_o), .if_ready_i(if_ready_i), .if_instr_o(if_instr_o),
    .if_pc_o(if_pc_o), .if_pc_plus4_o(if_pc_plus4_o), .redirect_i(redirect_i),
    .redirect_addr_i(redirect_addr_i), .illop_i(illop_i), .irq_i(irq_i),
    .xp_o(xp_o), .xp_valid_o(xp_valid_o)
  );

  always #5 clk = ~clk;

  // ROM model: unpopulated addresses return a recognisable junk word
  always_comb begin
    if ((pc_o / 4) < WORDS) id_i = rom[pc_o[8:2]];
    else                    id_i = 32'hBAD0_0000 ^ pc_o;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    redirect_i = 1'b0; redirect_addr_i = '0; illop_i = 1'b0; irq_i = 1'b0;
  endtask

  // One clock of the fetch stage described by its rules, applied to model state.
  task automatic model_step();
    logic [31:0] tgt;
    bit want_irq, in_rom;
    tgt      = {redirect_addr_i[31:2], 2'b00};
    want_irq = m_pend || irq_i;
    in_rom   = (m_pc / 4) < WORDS;
    m_xpv    = 1'b0;
    if (illop_i && m_v) begin
      m_xp = m_ipc + 4; m_xpv = 1'b1; m_pc = 32'd4; m_v = 1'b0; m_pend = want_irq;
    end else if (want_irq) begin
      m_xp   = redirect_i ? tgt + 4 : (m_v ? m_ipc + 4 : m_pc + 4);
      m_xpv  = 1'b1; m_pc = 32'd8; m_v = 1'b0; m_pend = 1'b0;
    end else if (redirect_i) begin
      m_pc = tgt; m_v = 1'b0;
    end else if (!in_rom) begin
      m_xp = m_pc + 4; m_xpv = 1'b1; m_pc = 32'd4; m_v = 1'b0;
    end else if (!m_v || if_ready_i) begin
      m_instr = rom[m_pc / 4];
      m_ipc   = m_pc;
      m_ip4   = m_pc + 4;
      m_pc    = m_pc + 4;
      m_v     = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; if_ready_i = 1'b1; clr_in();
    for (int i = 0; i < WORDS; i++) rom[i] = i;
    tick(); tick();
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("rst_instr", if_instr_o, 32'd0);
    chk("rst_ifpc", if_pc_o, 32'd0);
    chk("rst_xp", xp_o, 32'd0);
    chk("rst_xpv", {31'd0, xp_valid_o}, 32'd0);
    rst_n = 1'b1;

    // sequential fetch
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("seq_pc", pc_o, 32'(4 * (n + 1)));
      chk("seq_ifpc", if_pc_o, 32'(4 * n));
      chk("seq_instr", if_instr_o, 32'(n));
      chk("seq_p4", if_pc_plus4_o, 32'(4 * n + 4));
      chk("seq_valid", {31'd0, if_valid_o}, 32'd1);
    end

    // stall
    if_ready_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("stall_ifpc", if_pc_o, 32'd8);
      chk("stall_pc", pc_o, 32'd12);
      chk("stall_instr", if_instr_o, 32'd2);
      chk("stall_valid", {31'd0, if_valid_o}, 32'd1);
    end
    if_ready_i = 1'b1;
    tick();
    chk("unstall_ifpc", if_pc_o, 32'd12);
    chk("unstall_pc", pc_o, 32'd16);

    // redirect with misaligned target
    redirect_i = 1'b1; redirect_addr_i = 32'h52;
    tick();
    clr_in();
    chk("redir_pc", pc_o, 32'h50);
    chk("redir_bubble", {31'd0, if_valid_o}, 32'd0);
    tick();
    chk("redir_ifpc", if_pc_o, 32'h50);
    chk("redir_instr", if_instr_o, 32'h14);
    chk("redir_valid", {31'd0, if_valid_o}, 32'd1);

    // illop + redirect + irq together at if_pc=0x20
    redirect_i = 1'b1; redirect_addr_i = 32'h20;
    tick(); clr_in(); tick();
    chk("pre3_ifpc", if_pc_o, 32'h20);
    illop_i = 1'b1; redirect_i = 1'b1; redirect_addr_i = 32'h78; irq_i = 1'b1;
    tick();
    clr_in();
    chk("illop_pc", pc_o, 32'd4);
    chk("illop_xp", xp_o, 32'h24);
    chk("illop_xpv", {31'd0, xp_valid_o}, 32'd1);
    chk("illop_valid", {31'd0, if_valid_o}, 32'd0);
    tick();
    chk("irq_pc", pc_o, 32'd8);
    chk("irq_xp", xp_o, 32'd8);
    chk("irq_xpv", {31'd0, xp_valid_o}, 32'd1);
    tick();
    chk("post_irq_xpv", {31'd0, xp_valid_o}, 32'd0);
    chk("post_irq_xp_hold", xp_o, 32'd8);
    chk("post_irq_ifpc", if_pc_o, 32'd8);

    // run off the end of the ROM
    redirect_i = 1'b1; redirect_addr_i = 32'h1F8;
    tick(); clr_in(); tick(); tick();
    chk("end_ifpc", if_pc_o, 32'h1FC);
    chk("end_instr", if_instr_o, 32'h7F);
    chk("end_pc", pc_o, 32'h200);
    tick();
    chk("oor_pc", pc_o, 32'd4);
    chk("oor_xp", xp_o, 32'h204);
    chk("oor_xpv", {31'd0, xp_valid_o}, 32'd1);
    chk("oor_valid", {31'd0, if_valid_o}, 32'd0);
    tick();
    chk("oor_next_ifpc", if_pc_o, 32'd4);
    chk("oor_next_xpv", {31'd0, xp_valid_o}, 32'd0);

    // reset during a stall with an interrupt pending
    if_ready_i = 1'b0;
    tick();
    chk("st2_ifpc", if_pc_o, 32'd4);
    illop_i = 1'b1; irq_i = 1'b1;
    tick();
    clr_in();
    chk("pend_xpv", {31'd0, xp_valid_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc_o, 32'd0);
    chk("arst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("arst_xpv", {31'd0, xp_valid_o}, 32'd0);
    tick();
    rst_n = 1'b1; if_ready_i = 1'b1;
    tick();
    chk("norq_pc", pc_o, 32'd4);
    chk("norq_xpv", {31'd0, xp_valid_o}, 32'd0);
    tick();
    chk("norq_ifpc", if_pc_o, 32'd4);
    chk("norq_xpv2", {31'd0, xp_valid_o}, 32'd0);

    // randomized traffic against the model
    rst_n = 1'b0; clr_in();
    for (int i = 0; i < WORDS; i++) rom[i] = $urandom;
    tick();
    m_pc = 0; m_v = 0; m_instr = 0; m_ipc = 0; m_ip4 = 0; m_xp = 0; m_xpv = 0; m_pend = 0;
    rst_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if_ready_i = ($urandom_range(3) != 0);
      redirect_i = ($urandom_range(99) < 8);
      case ($urandom_range(3))
        0:       redirect_addr_i = 32'h1E0 + $urandom_range(63);
        1:       redirect_addr_i = 32'hFFFF_FFF0 + $urandom_range(15);
        default: redirect_addr_i = $urandom_range(511);
      endcase
      illop_i = ($urandom_range(99) < 5);
      irq_i   = ($urandom_range(99) < 3);
      model_step();
      tick();
      chk("rnd_pc", pc_o, m_pc);
      chk("rnd_valid", {31'd0, if_valid_o}, {31'd0, m_v});
      chk("rnd_xpv", {31'd0, xp_valid_o}, {31'd0, m_xpv});
      chk("rnd_xp", xp_o, m_xp);
      if (m_v) begin
        chk("rnd_instr", if_instr_o, m_instr);
        chk("rnd_ifpc", if_pc_o, m_ipc);
        chk("rnd_p4", if_pc_plus4_o, m_ip4);
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction ROM and downstream decode.
- Owns the program counter, drives the ROM address, and captures the returned instruction word into a fetch register.
- Presents the fetch register to decode with a valid/ready handshake.
- Applies branch/JMP redirects, illegal-op and interrupt vectoring, and guards against fetches beyond the populated ROM.

Parameters:
- RESET_ADDR, 32'd0, PC value after reset
- ILLOP_ADDR, 32'd4, vector taken on illegal op or out-of-range fetch
- XADR_ADDR, 32'd8, vector taken on interrupt
- IMEM_WORDS, 128, number of valid ROM words; legal PCs are 0 .. 4*IMEM_WORDS-4

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc_o  out  32  fetch address to ROM (registered)
- id_i  in  32  instruction word from ROM, combinational on pc_o
- if_valid_o  out  1  fetch register holds a live instruction
- if_ready_i  in  1  decode accepts fetch register this cycle
- if_instr_o  out  32  fetched instruction
- if_pc_o  out  32  address of if_instr_o
- if_pc_plus4_o  out  32  if_pc_o + 4, for linkage writes
- redirect_i  in  1  branch taken / JMP resolved this cycle
- redirect_addr_i  in  32  redirect target
- illop_i  in  1  decode flags if_instr_o as illegal (qualified by if_valid_o)
- irq_i  in  1  interrupt request pulse
- xp_o  out  32  exception return address
- xp_valid_o  out  1  one-cycle strobe: write xp_o to r30

Behaviour:
- Reset (async, rst_n=0):
  - pc_o=RESET_ADDR.
  - if_valid_o=0; if_instr_o=0; if_pc_o=0; xp_o=0; xp_valid_o=0.
  - irq pending flag=0.
- All state updates on the rising edge of clk.
- Reset deasserting mid-operation discards all in-flight state, including a pending irq.
- Targets:
  - Low 2 bits of every redirect target are forced to 0.
  - pc arithmetic is modulo 2^32 (wraps, no error).
- irq_i=1 sets a pending flag. The flag clears in the cycle the interrupt is taken. A second pulse while pending is absorbed.
- Out-of-range: (pc_o>>2) >= IMEM_WORDS. In that cycle id_i is ignored and is never loaded into the fetch register.
- Priority per cycle, highest first:
  1. illop_i & if_valid_o:
     - pc_o<=ILLOP_ADDR; if_valid_o<=0.
     - xp_o<=if_pc_o+4; xp_valid_o<=1.
     - Pending irq is kept, not taken.
  2. irq pending (flag, or irq_i this cycle):
     - pc_o<=XADR_ADDR; if_valid_o<=0; xp_valid_o<=1.
     - xp_o<= redirect_i ? target+4 : (if_valid_o ? if_pc_o+4 : pc_o+4).
     - Pending flag cleared.
  3. redirect_i:
     - pc_o<=target; if_valid_o<=0 (flush; one bubble).
  4. Out-of-range:
     - pc_o<=ILLOP_ADDR; if_valid_o<=0.
     - xp_o<=pc_o+4; xp_valid_o<=1.
  5. Advance when (!if_valid_o | if_ready_i):
     - if_instr_o<=id_i; if_pc_o<=pc_o; if_pc_plus4_o<=pc_o+4.
     - if_valid_o<=1; pc_o<=pc_o+4.
  6. Otherwise (stall):
     - All registers hold; pc_o holds so id_i stays stable.
- xp_valid_o is 0 in every cycle not listed above.
- xp_o holds its value between strobes.
- Flushes (cases 1–4) discard the fetch register even when if_ready_i=1 the same cycle. Decode must not consume on a flush cycle.
- Latency:
  - pc_o to if_valid_o: 1 cycle.
  - Redirect to first new instruction valid: 2 cycles.
  - Steady-state throughput: 1 instruction/cycle with if_ready_i=1.

Test Plan:
- Reset release, if_ready_i=1, ROM word n = n -> pc_o 0,4,8,12; if_pc_o 0,4,8 one cycle later; if_instr_o 0,1,2; if_pc_plus4_o 4,8,12.
- Hold if_ready_i=0 for 3 cycles with if_valid_o=1, if_pc_o=8 -> if_pc_o=8, pc_o=12 and if_instr_o stable all 3 cycles; release -> if_pc_o=12 next cycle.
- redirect_i with redirect_addr_i=0x52 -> next pc_o=0x50; if_valid_o=0 one cycle; then if_pc_o=0x50.
- illop_i, redirect_i (0x78) and irq_i in the same cycle, if_pc_o=0x20 -> pc_o=ILLOP_ADDR (4); xp_o=0x24; xp_valid_o=1 for one cycle; next cycle irq taken: pc_o=8, xp_o=pc_o+4=8 (PC then 4), second strobe.
- Run sequentially to pc_o=0x1FC with IMEM_WORDS=128 -> 0x1FC fetched; next cycle pc_o=0x200 out of range -> pc_o=4, xp_o=0x204, xp_valid_o=1; no instruction from 0x200 is ever valid.
- Assert rst_n=0 mid-stall with irq pending -> immediate pc_o=0, if_valid_o=0, xp_valid_o=0; after release no interrupt is taken.
